// File: rtl/rx_packet_buffer_if.sv
// Serial-in / packet-out bundle of rx_packet_buffer.
// master = the buffer itself, slave = the link driver plus packet consumer.
interface rx_packet_buffer_if #(
  parameter int PKT_W = 55,
  parameter int DEPTH = 4
);
  logic                         S_data;
  logic                         RX_Ready;
  logic                         RX_Data_Valid;
  logic [PKT_W-1:0]             RX_Data;
  logic [$clog2(DEPTH+1)-1:0]   RX_Count;
  logic                         RX_Overflow;
  logic                         RX_Parity_Err;

  modport master (
    input  S_data, RX_Ready,
    output RX_Data_Valid, RX_Data, RX_Count, RX_Overflow, RX_Parity_Err
  );

  modport slave (
    output S_data, RX_Ready,
    input  RX_Data_Valid, RX_Data, RX_Count, RX_Overflow, RX_Parity_Err
  );
endinterface

// File: rtl/rx_packet_buffer.sv
// Start-bit framed serial packet receiver feeding a DEPTH-entry packet queue.
// Optional even-parity bit after the data enabled by defining RX_PARITY_EN.
module rx_packet_buffer #(
  parameter int PKT_W = 55,
  parameter int DEPTH = 4
) (
  input logic                Clk_S,
  input logic                Rst,
  rx_packet_buffer_if.master rx
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int BIT_W = $clog2(PKT_W);

`ifdef RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t             state_reg;
  logic [BIT_W-1:0]   cnt_reg;
  logic [PKT_W-1:0]   shift_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               ovf_reg;
  logic               perr_reg;

  logic               frame_done;
  logic               parity_ok;
  logic [PKT_W-1:0]   frame_word;
  logic               pop;
  logic               full;
  logic               push;
  logic               ovf_next;
  logic               perr_next;

  always_comb begin
    pop  = rx.RX_Ready && (count_reg != '0);
    full = (count_reg == CNT_W'(DEPTH));
`ifdef RX_PARITY_EN
    frame_done = (state_reg == PAR);
    frame_word = shift_reg;
    parity_ok  = ~(^{shift_reg, rx.S_data});
`else
    // The last data bit is committed straight from the line on the same edge.
    frame_done = (state_reg == SHIFT) && (cnt_reg == '0);
    frame_word = {shift_reg[PKT_W-2:0], rx.S_data};
    parity_ok  = 1'b1;
`endif
    push      = frame_done && parity_ok && (!full || pop);
    ovf_next  = frame_done && parity_ok && full && !pop;
    perr_next = frame_done && !parity_ok;
  end

  always_ff @(posedge Clk_S or posedge Rst) begin
    if (Rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shift_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rx.S_data) begin
            state_reg <= SHIFT;
            cnt_reg   <= BIT_W'(PKT_W - 1);
          end
        end
        SHIFT: begin
          shift_reg <= {shift_reg[PKT_W-2:0], rx.S_data};
          cnt_reg   <= cnt_reg - BIT_W'(1);
          if (cnt_reg == '0) begin
`ifdef RX_PARITY_EN
            state_reg <= PAR;
`else
            state_reg <= IDLE;
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk_S or posedge Rst) begin
    if (Rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
      perr_reg   <= 1'b0;
    end else begin
      ovf_reg  <= ovf_next;
      perr_reg <= perr_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Register-based slots so the head is visible the cycle right after a push/pop.
  logic [PKT_W-1:0] slot_q [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [PKT_W-1:0] entry_reg;
    always_ff @(posedge Clk_S or posedge Rst) begin
      if (Rst)
        entry_reg <= '0;
      else if (push && (wr_ptr_reg == PTR_W'(gi)))
        entry_reg <= frame_word;
    end
    assign slot_q[gi] = entry_reg;
  end

  assign rx.RX_Data       = slot_q[rd_ptr_reg];
  assign rx.RX_Data_Valid = (count_reg != '0);
  assign rx.RX_Count      = count_reg;
  assign rx.RX_Overflow   = ovf_reg;
`ifdef RX_PARITY_EN
  assign rx.RX_Parity_Err = perr_reg;
`else
  assign rx.RX_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_packet_buffer.sv
// Directed + randomized bench for rx_packet_buffer (PKT_W=8, DEPTH=4) against a queue model.
// Honours RX_PARITY_EN the same way as the design.
module tb_rx_packet_buffer;
  localparam int PKT_W = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  logic [PKT_W-1:0] mq [$];

  rx_packet_buffer_if #(.PKT_W(PKT_W), .DEPTH(DEPTH)) rxif ();

  rx_packet_buffer #(.PKT_W(PKT_W), .DEPTH(DEPTH)) dut (
    .Clk_S (clk),
    .Rst   (rst),
    .rx    (rxif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(rxif.RX_Data_Valid), 32'd0);
    check({tag, "_data"},  32'(rxif.RX_Data),       32'd0);
    check({tag, "_count"}, 32'(rxif.RX_Count),      32'd0);
    check({tag, "_ovf"},   32'(rxif.RX_Overflow),   32'd0);
    check({tag, "_perr"},  32'(rxif.RX_Parity_Err), 32'd0);
  endtask

  // One clock: drive line/ready, advance the queue model for that edge, compare.
  task automatic tick(input logic sbit, input logic rdy, input logic commit,
                      input logic [PKT_W-1:0] word, input logic bad);
    bit   pop, full;
    logic exp_ovf, exp_perr;
    rxif.S_data   = sbit;
    rxif.RX_Ready = rdy;
    pop  = rdy && (mq.size() > 0);
    full = (mq.size() == DEPTH);
    @(posedge clk);
    #1;
    exp_ovf  = 1'b0;
    exp_perr = 1'b0;
    if (pop) void'(mq.pop_front());
    if (commit) begin
      if (bad)               exp_perr = 1'b1;
      else if (full && !pop) exp_ovf  = 1'b1;
      else                   mq.push_back(word);
    end
    check("count", 32'(rxif.RX_Count),      32'(mq.size()));
    check("valid", 32'(rxif.RX_Data_Valid), 32'(mq.size() > 0));
    check("ovf",   32'(rxif.RX_Overflow),   32'(exp_ovf));
    check("perr",  32'(rxif.RX_Parity_Err), 32'(exp_perr));
    if (mq.size() > 0)
      check("head", 32'(rxif.RX_Data), 32'(mq[0]));
  endtask

  // mode: 0 never ready, 1 always ready, 2 ready only on the commit cycle, 3 random
  function automatic logic rdy_for(input int mode, input logic at_commit);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return at_commit;
      default: return logic'($urandom_range(1, 0));
    endcase
  endfunction

  task automatic send_frame(input logic [PKT_W-1:0] w, input int mode, input logic par_bit);
    tick(1'b1, rdy_for(mode, 1'b0), 1'b0, w, 1'b0);
    for (int i = PKT_W - 1; i >= 0; i--) begin
`ifdef RX_PARITY_EN
      tick(w[i], rdy_for(mode, 1'b0), 1'b0, w, 1'b0);
`else
      tick(w[i], rdy_for(mode, i == 0), i == 0, w, 1'b0);
`endif
    end
`ifdef RX_PARITY_EN
    tick(par_bit, rdy_for(mode, 1'b1), 1'b1, w, (^w) ^ par_bit);
`endif
    $display("[TB] frame %02h par %0b mode %0d -> count %0d ovf %0b perr %0b",
             w, par_bit, mode, rxif.RX_Count, rxif.RX_Overflow, rxif.RX_Parity_Err);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) tick(1'b0, rdy, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [PKT_W-1:0] w;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    rxif.S_data   = 1'b0;
    rxif.RX_Ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    idle(2, 1'b1);

    // single frame, no consumer
    send_frame(8'hA5, 0, ^8'hA5);
    idle(2, 1'b0);
    idle(2, 1'b1);

    // fill, overflow on the fifth, drain in order
    for (int k = 1; k <= 5; k++) send_frame(PKT_W'(k), 0, ^PKT_W'(k));
    idle(5, 1'b1);

    // full queue, fifth commits with a simultaneous pop
    for (int k = 1; k <= 4; k++) send_frame(PKT_W'(k), 0, ^PKT_W'(k));
    send_frame(8'h05, 2, ^8'h05);
    idle(5, 1'b1);

    // streaming with ready held, pointers wrap
    for (int k = 0; k < 6; k++) send_frame(PKT_W'(8'h10 + k), 1, ^PKT_W'(8'h10 + k));
    idle(2, 1'b1);

    // reset in the middle of a frame with a packet already queued
    send_frame(8'h77, 0, ^8'h77);
    tick(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, '0, 1'b0);
    @(posedge clk);
    rst = 1'b1;
    rxif.S_data = 1'b0;
    #1;
    check_zero("midrst");
    mq.delete();
    @(posedge clk);
    #1;
    check_zero("midrst_hold");
    rst = 1'b0;
    idle(2, 1'b0);
    send_frame(8'h3C, 0, ^8'h3C);
    idle(3, 1'b1);

`ifdef RX_PARITY_EN
    send_frame(8'hA5, 0, 1'b1);
    idle(1, 1'b0);
    send_frame(8'hA5, 0, 1'b0);
    // bad parity while full reports parity error only
    for (int k = 1; k <= 3; k++) send_frame(PKT_W'(k), 0, ^PKT_W'(k));
    send_frame(8'h0F, 0, 1'b1);
    idle(5, 1'b1);
`endif

    // randomized traffic with random consumer
    for (int k = 0; k < 60; k++) begin
      w = PKT_W'($urandom);
      send_frame(w, 3, (^w) ^ ($urandom_range(7, 0) == 0));
      idle($urandom_range(2, 0), logic'($urandom_range(1, 0)));
    end
    idle(6, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
